mips_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the MIPSProcessor core; owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU as a multi-cycle operation under a start/busy/done handshake.
- Also executes MTHI/MTLO as single-cycle writes.
- The core stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mips_muldiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; MTHI/MTLO write in one edge.
// Latency WIDTH+2 cycles from accept to done; no backpressure, starts while busy are dropped.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 is_div_q, is_div_d;
    logic                 sgn_q, sgn_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_q, dbz_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign a_neg = sgn_q & a_q[WIDTH-1];
    assign b_neg = sgn_q & b_q[WIDTH-1];
    assign a_mag = a_neg ? (-a_q) : a_q;
    assign b_mag = b_neg ? (-b_q) : b_q;

    // Multiply: p holds {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);

    // Divide: p holds {remainder, dividend/quotient}; trial-subtract the shifted remainder.
    assign div_shift = p_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, m_q};

    assign prod_fix = neg_res_q ? (-p_q) : p_q;
    assign quo_fix  = neg_res_q ? (-p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (-p_q[2*WIDTH-1:WIDTH]) : p_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        sgn_d     = sgn_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (!op[2]) begin
                        a_d      = a;
                        b_d      = b;
                        is_div_d = op[1];
                        sgn_d    = ~op[0];
                        dbz_d    = 1'b0;
                        state_d  = S_PREP;
                    end else if (!op[1]) begin
                        if (op[0]) begin
                            lo_d = a;
                        end else begin
                            hi_d = a;
                        end
                    end
                end
            end
            S_PREP: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = CNT_W'(WIDTH);
                    dbz_d     = is_div_q && (b_q == '0);
                    if (is_div_q) begin
                        m_d = b_mag;
                        p_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        m_d = a_mag;
                        p_d = {{WIDTH{1'b0}}, b_mag};
                    end
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                        end else begin
                            p_d = {p_q[2*WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        p_d = {mul_sum, p_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (dbz_q) begin
                        // Divide-by-zero result is architecturally fixed, not what the array produced.
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            sgn_q     <= 1'b0;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            sgn_q     <= sgn_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: expected HI/LO queued at start, compared on done.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model built from the language's own arithmetic.
    function automatic exp_t model(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        r;
        logic [63:0] pu;
        r.tag = tag;
        r.dbz = 1'b0;
        r.hi  = '0;
        r.lo  = '0;
        case (o)
            3'b000, 3'b001: begin
                if (o == 3'b000) pu = {{32{x[31]}}, x} * {{32{y[31]}}, y};
                else             pu = {32'b0, x} * {32'b0, y};
                r.hi = pu[63:32];
                r.lo = pu[31:0];
            end
            default: begin
                if (y == '0) begin
                    r.dbz = 1'b1;
                    r.hi  = x;
                    r.lo  = '1;
                end else if (o == 3'b010 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r.hi = '0;
                    r.lo = x;
                end else if (o == 3'b010) begin
                    r.lo = $signed(x) / $signed(y);
                    r.hi = $signed(x) % $signed(y);
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 64'(done), 64'd0);
            end else begin
                cur = sb_q.pop_front();
                check_eq({cur.tag, "_hi"}, 64'(hi), 64'(cur.hi));
                check_eq({cur.tag, "_lo"}, 64'(lo), 64'(cur.lo));
                check_eq({cur.tag, "_dbz"}, 64'(div_by_zero), 64'(cur.dbz));
            end
        end
    end

    // Drives one MULT/DIV, optionally injecting an MTLO start inj_cyc cycles in.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz, input int inj_cyc);
        exp_t e;
        int   cyc;
        int   busy_cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        e.tag = tag; e.hi = ehi; e.lo = elo; e.dbz = edbz;
        sb_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        check_eq({tag, "_dbz_clr"}, 64'(div_by_zero), 64'd0);
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == inj_cyc) begin
                start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 64'(cyc), 64'(W + 2));
        check_eq({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(W + 2));
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dn;
        exp_t m;
        logic [2:0]   ro;
        logic [W-1:0] rx, ry;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_m3x7",  3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
        run_op("multu_max",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1);
        run_op("mult_m1m1",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, -1);
        run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1);
        run_op("div_m7_2",   3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
        run_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, -1);
        run_op("div_by0",    3'b010, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, -1);
        repeat (3) @(posedge clk);
        #1 check_eq("dbz_sticky", 64'(div_by_zero), 64'd1);

        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hAAAA_5555;
        @(negedge clk);
        check_eq("mthi_hi", 64'(hi), 64'hAAAA_5555);
        check_eq("mthi_done", 64'(done), 64'd0);
        op = 3'b101; a = 32'h0F0F_0F0F;
        @(negedge clk);
        start = 1'b0;
        check_eq("mtlo_lo", 64'(lo), 64'h0F0F_0F0F);
        check_eq("mtlo_hi_kept", 64'(hi), 64'hAAAA_5555);
        check_eq("mtlo_done", 64'(done), 64'd0);

        run_op("multu_3x5_mtlo", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 10);

        // Flush in RUN cycle 5: no done, HI/LO retained.
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd12345; b = 32'd678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        check_eq("flush_busy_before", 64'(busy), 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        check_eq("flush_no_done", 64'(dn), 64'd0);
        check_eq("flush_hi", 64'(hi), 64'd0);
        check_eq("flush_lo", 64'(lo), 64'd15);

        // Flush wins over a same-cycle start in IDLE.
        @(negedge clk);
        start = 1'b1; op = 3'b001; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check_eq("idle_flush_busy", 64'(busy), 64'd0);

        // Asynchronous reset during a divide-by-zero run.
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd5; b = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("pre_rst_dbz", 64'(div_by_zero), 64'd1);
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_hi", 64'(hi), 64'd0);
        check_eq("arst_lo", 64'(lo), 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_done", 64'(done), 64'd0);
        check_eq("arst_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op("divu_9_3", 3'b011, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i % 4 == 3) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            m = model($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry);
            run_op(m.tag, ro, rx, ry, m.hi, m.lo, m.dbz, -1);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
